shift_sequencer: RTL

Parametrised serial shift engine with parallel load, selectable direction, and a counted shift burst.
- Shifts a programmable number of bits (1..WIDTH) in or out of a WIDTH-bit register, then returns to idle with a one-cycle done pulse.
- Serves the serial capture/emit paths of the angle generator: tooth-pattern sampling and configuration shift-out.
- Successor to the fixed left-shift-with-load register: adds direction, burst counting, gated stepping and a busy/done handshake.

---
 rtl/shift_sequencer.sv | 112 +++++++++++
 1 files changed

// File: rtl/shift_sequencer.sv
// Counted serial shift engine with parallel load and selectable direction.
// Optional rotate fill is enabled by defining SHIFT_SEQ_ROTATE_EN.
module shift_sequencer #(
  parameter int WIDTH = 8,
  parameter int LEN_W = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic             sload,
  input  logic [WIDTH-1:0] load_data,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             dir,
  input  logic             sd_in,
`ifdef SHIFT_SEQ_ROTATE_EN
  input  logic             rot,
`endif
  output logic [WIDTH-1:0] q,
  output logic             sd_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] q_nx;
  logic [LEN_W-1:0] cnt, cnt_nx, eff_len;
  logic             dir_r, dir_nx;
  logic             done_nx;
  logic             out_bit;
  logic             fill;

  localparam logic [LEN_W-1:0] WMAX = LEN_W'(WIDTH);

  assign eff_len = (len == '0 || len > WMAX) ? WMAX : len;
  assign out_bit = dir_r ? q[0] : q[WIDTH-1];
  assign sd_out  = out_bit;
  assign busy    = (state == SHIFT);

`ifdef SHIFT_SEQ_ROTATE_EN
  logic rot_r, rot_nx;
  assign fill = rot_r ? out_bit : sd_in;
`else
  assign fill = sd_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      dir_r <= 1'b0;
      done  <= 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_r <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      q     <= q_nx;
      cnt   <= cnt_nx;
      dir_r <= dir_nx;
      done  <= done_nx;
`ifdef SHIFT_SEQ_ROTATE_EN
      rot_r <= rot_nx;
`endif
    end
  end

  always_comb begin
    state_nx = state;
    q_nx     = q;
    cnt_nx   = cnt;
    dir_nx   = dir_r;
    done_nx  = 1'b0;
`ifdef SHIFT_SEQ_ROTATE_EN
    rot_nx   = rot_r;
`endif
    // a load always wins and silently aborts any burst
    if (sload) begin
      q_nx     = load_data;
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            dir_nx   = dir;
            cnt_nx   = eff_len;
            state_nx = SHIFT;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_nx   = rot;
`endif
          end
        end
        SHIFT: begin
          if (ena) begin
            q_nx   = dir_r ? {fill, q[WIDTH-1:1]}
                           : {q[WIDTH-2:0], fill};
            cnt_nx = cnt - LEN_W'(1);
            if (cnt == LEN_W'(1)) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

endmodule
